axis_hdr_pkt_gen: RTL and testbench
===================================

Name: axis_hdr_pkt_gen

Overview:
- Parametrised, deterministic stimulus and sink block for the AXI-Stream header-insert datapath.
- Emits one header on the insert channel per packet, then a multi-beat packet on the data channel. Last-beat keep is MSB-aligned.
- Drives ready_out with a programmable backpressure pattern and counts packets and beats returned by the DUT.
- Replaces free-running $random stimulus with seeded LFSR and incrementing patterns, so runs are repeatable and checkable.

Parameters:
- DATA_WD, 32, data bus width in bits; must be a multiple of 8, 16..512.
- DATA_BYTE_WD, DATA_WD/8, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte-count fields.
- LEN_WD, 8, width of packet-length (beats) fields.
- CNT_WD, 16, width of status counters.
- GAP_CYCLES, 2, idle cycles between packets; 0 is allowed.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run of cfg_num_pkts packets
- cfg_num_pkts  in  CNT_WD  packets per run; 0 means the run completes immediately
- cfg_max_beats  in  LEN_WD  maximum body beats per packet; 0 is treated as 1
- cfg_seed  in  32  LFSR seed; loaded on start; 0 is replaced by 32'h1
- cfg_pattern  in  1  0 = incrementing bytes, 1 = LFSR data
- cfg_bp_en  in  1  enables random backpressure on ready_out
- valid_in / data_in[DATA_WD] / keep_in[DATA_BYTE_WD] / last_in  out  data channel to DUT
- ready_in  in  1  DUT accepts data beat
- valid_insert / data_insert[DATA_WD] / keep_insert[DATA_BYTE_WD] / byte_insert_cnt[BYTE_CNT_WD]  out  header channel
- ready_insert  in  1  DUT accepts header
- valid_out / data_out[DATA_WD] / keep_out[DATA_BYTE_WD] / last_out  in  DUT output stream
- ready_out  out  1  sink ready
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the final packet's last beat is accepted
- pkt_sent_cnt / pkt_rcvd_cnt / beat_rcvd_cnt  out  CNT_WD  status counters

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous and active-low.
- Reset values:
  - all valid outputs, last_in, busy, done, and all counters are 0;
  - data, keep and byte_insert_cnt are 0;
  - FSM is in IDLE; LFSRs hold 32'h1.
- Reset mid-packet aborts the packet immediately, with no completion of the open transfer.
- FSM states: IDLE -> HDR -> BODY -> GAP -> HDR, or back to IDLE.
- IDLE:
  - start with cfg_num_pkts != 0 latches all cfg_* inputs, loads the LFSRs, sets busy and enters HDR next cycle.
  - start with cfg_num_pkts == 0 pulses done and stays in IDLE.
  - start while busy is ignored.
- HDR:
  - On entry, draw from the LFSR: hdr_cnt = lfsr[BYTE_CNT_WD-1:0] and len = min(lfsr[LEN_WD+7:8], max-1) + 1.
  - Drive valid_insert=1, byte_insert_cnt=hdr_cnt and keep_insert = LSB-aligned (hdr_cnt+1) ones. Example: cnt 1 gives 4'b0011.
  - data_insert = {pkt_idx, 8'hA5} zero-extended/truncated to DATA_WD.
  - On valid_insert && ready_insert, go to BODY next cycle.
- BODY:
  - valid_in=1 for len beats; a beat advances only on valid_in && ready_in.
  - Non-last keep is all ones. On the last beat, last_in=1; tail = lfsr[BYTE_CNT_WD-1:0] drawn at HDR; keep = MSB-aligned (tail+1) ones. Example: tail 1 gives 4'b1100.
  - Data for cfg_pattern=0: byte k of beat b = (b*DATA_BYTE_WD + k) mod 256.
  - Data for cfg_pattern=1: the LFSR word; the LFSR steps once per accepted beat.
  - Accepting the last beat increments pkt_sent_cnt. If that was the final packet, pulse done, clear busy and go to IDLE. Otherwise go to GAP, or straight to HDR when GAP_CYCLES=0.
- GAP: valid_in=0 and valid_insert=0 for GAP_CYCLES cycles.
- AXI rules:
  - once a valid is asserted, it and its payload hold stable until accepted;
  - valid never depends combinationally on ready;
  - the two channels are never valid in the same cycle.
- Sink:
  - ready_out = 1 when cfg_bp_en=0; otherwise ready_out = a bit of an independent LFSR (seed ~cfg_seed), registered and stepped every cycle while busy.
  - The sink is independent of the source FSM.
  - beat_rcvd_cnt increments on valid_out && ready_out; pkt_rcvd_cnt additionally requires last_out.
- Counters wrap at 2^CNT_WD; they clear on reset and on an accepted start.
- LFSR: 32-bit Galois, polynomial 32'h80200003, stepping on the events stated above.

Decomposition:
- Shared package axis_gen_pkg holds:
  - LFSR_POLY and DEF_SEED;
  - state enum {IDLE, HDR, BODY, GAP};
  - functions keep_lsb(cnt) and keep_msb(cnt), parametrised on DATA_BYTE_WD.
- Sub-module lfsr32 (step, load, seed in; value out) is instantiated twice: source and backpressure.

Test Plan:
- Reset then start with num_pkts=1, max_beats=1, seed=1, pattern=0, ready tied 1 -> one header (valid_insert for one cycle) then one beat: last_in=1, data 32'h03020100, keep MSB-aligned per tail; done pulses; pkt_sent_cnt=1.
- Num_pkts=3, max_beats=4, GAP_CYCLES=2, ready_in held 0 for 5 cycles mid-packet -> data_in and keep_in stable while stalled; exactly 2 idle cycles between packets; pkt_sent_cnt=3.
- Sweep tail/hdr_cnt over 0..3 (DATA_WD=32) -> keep_insert is 0001/0011/0111/1111 and last-beat keep_in is 1000/1100/1110/1111.
- Same seed run twice with pattern=1 -> identical data_in sequences; a different seed gives a different sequence.
- Loopback data channel to output with cfg_bp_en=1 over 100 packets -> pkt_rcvd_cnt=100 and beat_rcvd_cnt equals total beats sent; ready_out toggles.
- rst_n low mid-BODY for 1 cycle -> all valids 0 the next cycle, counters 0, FSM in IDLE; start with num_pkts=0 -> done pulses and busy stays 0.

Source files
------------

// File: rtl/axis_gen_pkg.sv
// Shared types, constants and helpers for the AXI-Stream header-insert stimulus generator.
package axis_gen_pkg;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;
  localparam logic [31:0] DEF_SEED  = 32'h1;
  localparam int unsigned MAX_BYTES = 64;

  typedef enum logic [1:0] {IDLE, HDR, BODY, GAP} gen_state_e;

  // Right-shifting Galois step
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? DEF_SEED : s;
  endfunction

  // (cnt+1) ones starting at byte 0
  function automatic logic [MAX_BYTES-1:0] keep_lsb(input int unsigned cnt);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      if (i <= cnt) k[i] = 1'b1;
    return k;
  endfunction

  // (cnt+1) ones ending at byte nbytes-1
  function automatic logic [MAX_BYTES-1:0] keep_msb(input int unsigned nbytes,
                                                    input int unsigned cnt);
    logic [MAX_BYTES-1:0] k;
    k = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      if ((i < nbytes) && (i + cnt + 1 >= nbytes)) k[i] = 1'b1;
    return k;
  endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load; zero seeds are replaced by DEF_SEED.
module lfsr32
  import axis_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        load,
  input  logic [31:0] seed,
  output logic [31:0] value
);

  always_ff @(posedge clk) begin
    if (!rst_n)    value <= DEF_SEED;
    else if (load) value <= seed_fix(seed);
    else if (step) value <= lfsr_next(value);
  end

endmodule

// File: rtl/axis_hdr_pkt_gen.sv
// Repeatable header + packet source and backpressuring sink for the header-insert datapath.
module axis_hdr_pkt_gen
  import axis_gen_pkg::*;
#(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned LEN_WD       = 8,
  parameter int unsigned CNT_WD       = 16,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_WD-1:0]       cfg_num_pkts,
  input  logic [LEN_WD-1:0]       cfg_max_beats,
  input  logic [31:0]             cfg_seed,
  input  logic                    cfg_pattern,
  input  logic                    cfg_bp_en,
  output logic                    valid_in,
  output logic [DATA_WD-1:0]      data_in,
  output logic [DATA_BYTE_WD-1:0] keep_in,
  output logic                    last_in,
  input  logic                    ready_in,
  output logic                    valid_insert,
  output logic [DATA_WD-1:0]      data_insert,
  output logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  input  logic                    ready_insert,
  input  logic                    valid_out,
  input  logic [DATA_WD-1:0]      data_out,
  input  logic [DATA_BYTE_WD-1:0] keep_out,
  input  logic                    last_out,
  output logic                    ready_out,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WD-1:0]       pkt_sent_cnt,
  output logic [CNT_WD-1:0]       pkt_rcvd_cnt,
  output logic [CNT_WD-1:0]       beat_rcvd_cnt
);

  localparam int unsigned GAP_WD = 16;
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

  gen_state_e state_q, state_d;
  logic [CNT_WD-1:0]       num_q, num_d, pkt_idx_q, pkt_idx_d, pkt_sent_d;
  logic [LEN_WD-1:0]       max_q, max_d, len_q, len_d, beat_q, beat_d;
  logic [LEN_WD-1:0]       lim_c, raw_c;
  logic [BYTE_CNT_WD-1:0]  tail_q, tail_d, byte_insert_cnt_d;
  logic [GAP_WD-1:0]       gap_q, gap_d;
  logic                    pat_q, pat_d, bp_q, bp_d;
  logic                    busy_d, done_d, valid_insert_d, valid_in_d, last_in_d;
  logic [DATA_WD-1:0]      data_insert_d, data_in_d;
  logic [DATA_BYTE_WD-1:0] keep_insert_d, keep_in_d;
  logic                    src_load_c, src_step_c, draw_c, load_beat_c;
  logic                    start_acc_c, run_load_c;
  logic [31:0]             src_lfsr, bp_lfsr, src_after_c;
  logic                    sink_unused_c;

  assign start_acc_c = start && (state_q == IDLE);
  assign run_load_c  = start_acc_c && (cfg_num_pkts != '0);

  lfsr32 u_src_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (src_step_c),
    .load  (src_load_c),
    .seed  (cfg_seed),
    .value (src_lfsr)
  );

  lfsr32 u_bp_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (busy),
    .load  (run_load_c),
    .seed  (~cfg_seed),
    .value (bp_lfsr)
  );

  function automatic logic [DATA_WD-1:0] inc_beat(input logic [LEN_WD-1:0] b);
    logic [DATA_WD-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < DATA_BYTE_WD; k++)
      w[k*8 +: 8] = 8'(32'(b) * DATA_BYTE_WD + k);
    return w;
  endfunction

  // Wider buses repeat the 32-bit LFSR word
  function automatic logic [DATA_WD-1:0] rep_lfsr(input logic [31:0] v);
    logic [DATA_WD-1:0] w;
    w = '0;
    for (int unsigned k = 0; k < DATA_BYTE_WD; k++)
      w[k*8 +: 8] = v[(k % 4)*8 +: 8];
    return w;
  endfunction

  // Source FSM: next state and next registered outputs
  always_comb begin
    state_d           = state_q;
    num_d             = num_q;
    max_d             = max_q;
    pat_d             = pat_q;
    bp_d              = bp_q;
    pkt_idx_d         = pkt_idx_q;
    len_d             = len_q;
    beat_d            = beat_q;
    tail_d            = tail_q;
    gap_d             = gap_q;
    busy_d            = busy;
    done_d            = 1'b0;
    pkt_sent_d        = pkt_sent_cnt;
    valid_insert_d    = valid_insert;
    data_insert_d     = data_insert;
    keep_insert_d     = keep_insert;
    byte_insert_cnt_d = byte_insert_cnt;
    valid_in_d        = valid_in;
    data_in_d         = data_in;
    keep_in_d         = keep_in;
    last_in_d         = last_in;
    src_load_c        = 1'b0;
    src_step_c        = 1'b0;
    draw_c            = 1'b0;
    load_beat_c       = 1'b0;
    lim_c             = '0;
    raw_c             = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          pkt_sent_d = '0;
          if (cfg_num_pkts == '0) begin
            done_d = 1'b1;
          end else begin
            src_load_c = 1'b1;
            busy_d     = 1'b1;
            num_d      = cfg_num_pkts;
            max_d      = cfg_max_beats;
            pat_d      = cfg_pattern;
            bp_d       = cfg_bp_en;
            pkt_idx_d  = '0;
            draw_c     = 1'b1;
            state_d    = HDR;
          end
        end
      end
      HDR: begin
        if (valid_insert && ready_insert) begin
          valid_insert_d = 1'b0;
          beat_d         = '0;
          load_beat_c    = 1'b1;
          state_d        = BODY;
        end
      end
      BODY: begin
        if (valid_in && ready_in) begin
          src_step_c = 1'b1;
          if (last_in) begin
            pkt_sent_d = pkt_sent_cnt + CNT_WD'(1);
            valid_in_d = 1'b0;
            last_in_d  = 1'b0;
            if (pkt_idx_q == num_q - CNT_WD'(1)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              pkt_idx_d = pkt_idx_q + CNT_WD'(1);
              if (GAP_CYCLES == 0) begin
                draw_c  = 1'b1;
                state_d = HDR;
              end else begin
                gap_d   = '0;
                state_d = GAP;
              end
            end
          end else begin
            beat_d      = beat_q + LEN_WD'(1);
            load_beat_c = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_WD'(GAP_CYCLES - 1)) begin
          draw_c  = 1'b1;
          state_d = HDR;
        end else begin
          gap_d = gap_q + GAP_WD'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Value the source LFSR holds after this edge; header and beat data draw from it
    src_after_c = src_load_c ? seed_fix(cfg_seed)
                : (src_step_c ? lfsr_next(src_lfsr) : src_lfsr);

    if (draw_c) begin
      lim_c             = (max_d == '0) ? '0 : max_d - LEN_WD'(1);
      raw_c             = src_after_c[LEN_WD+7:8];
      len_d             = ((raw_c > lim_c) ? lim_c : raw_c) + LEN_WD'(1);
      tail_d            = src_after_c[BYTE_CNT_WD-1:0];
      valid_insert_d    = 1'b1;
      byte_insert_cnt_d = tail_d;
      keep_insert_d     = DATA_BYTE_WD'(keep_lsb(32'(tail_d)));
      data_insert_d     = DATA_WD'({pkt_idx_d, 8'hA5});
    end

    if (load_beat_c) begin
      valid_in_d = 1'b1;
      last_in_d  = (beat_d == len_d - LEN_WD'(1));
      data_in_d  = pat_q ? rep_lfsr(src_after_c) : inc_beat(beat_d);
      keep_in_d  = last_in_d ? DATA_BYTE_WD'(keep_msb(DATA_BYTE_WD, 32'(tail_q))) : KEEP_ALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      num_q           <= '0;
      max_q           <= '0;
      pat_q           <= 1'b0;
      bp_q            <= 1'b0;
      pkt_idx_q       <= '0;
      len_q           <= '0;
      beat_q          <= '0;
      tail_q          <= '0;
      gap_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pkt_sent_cnt    <= '0;
      valid_insert    <= 1'b0;
      data_insert     <= '0;
      keep_insert     <= '0;
      byte_insert_cnt <= '0;
      valid_in        <= 1'b0;
      data_in         <= '0;
      keep_in         <= '0;
      last_in         <= 1'b0;
    end else begin
      state_q         <= state_d;
      num_q           <= num_d;
      max_q           <= max_d;
      pat_q           <= pat_d;
      bp_q            <= bp_d;
      pkt_idx_q       <= pkt_idx_d;
      len_q           <= len_d;
      beat_q          <= beat_d;
      tail_q          <= tail_d;
      gap_q           <= gap_d;
      busy            <= busy_d;
      done            <= done_d;
      pkt_sent_cnt    <= pkt_sent_d;
      valid_insert    <= valid_insert_d;
      data_insert     <= data_insert_d;
      keep_insert     <= keep_insert_d;
      byte_insert_cnt <= byte_insert_cnt_d;
      valid_in        <= valid_in_d;
      data_in         <= data_in_d;
      keep_in         <= keep_in_d;
      last_in         <= last_in_d;
    end
  end

  // Sink: only handshakes are counted, the returned payload is not inspected
  assign sink_unused_c = ^{data_out, keep_out, bp_lfsr[31:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_out     <= 1'b0;
      pkt_rcvd_cnt  <= '0;
      beat_rcvd_cnt <= '0;
    end else begin
      ready_out <= bp_q ? bp_lfsr[0] : 1'b1;
      if (start_acc_c) begin
        pkt_rcvd_cnt  <= '0;
        beat_rcvd_cnt <= '0;
      end else if (valid_out && ready_out) begin
        beat_rcvd_cnt <= beat_rcvd_cnt + CNT_WD'(1);
        if (last_out) pkt_rcvd_cnt <= pkt_rcvd_cnt + CNT_WD'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_hdr_pkt_gen.sv
// Directed self-checking bench for axis_hdr_pkt_gen (32-bit bus, two gap cycles).
module tb_axis_hdr_pkt_gen;

  localparam int unsigned DW  = 32;
  localparam int unsigned BW  = 4;
  localparam int unsigned BCW = 2;
  localparam int unsigned LW  = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned GAP = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [CW-1:0]  cfg_num_pkts = '0;
  logic [LW-1:0]  cfg_max_beats = '0;
  logic [31:0]    cfg_seed = '0;
  logic           cfg_pattern = 1'b0;
  logic           cfg_bp_en = 1'b0;
  logic           valid_in, last_in, ready_in;
  logic [DW-1:0]  data_in;
  logic [BW-1:0]  keep_in;
  logic           valid_insert;
  logic [DW-1:0]  data_insert;
  logic [BW-1:0]  keep_insert;
  logic [BCW-1:0] byte_insert_cnt;
  logic           ready_insert = 1'b1;
  logic           valid_out, last_out, ready_out;
  logic [DW-1:0]  data_out;
  logic [BW-1:0]  keep_out;
  logic           busy, done;
  logic [CW-1:0]  pkt_sent_cnt, pkt_rcvd_cnt, beat_rcvd_cnt;

  logic loop_en = 1'b0;
  logic rdy_drv = 1'b1;

  // Optional loopback of the data channel into the sink
  assign ready_in  = loop_en ? ready_out : rdy_drv;
  assign valid_out = loop_en & valid_in;
  assign data_out  = data_in;
  assign keep_out  = keep_in;
  assign last_out  = loop_en & last_in;

  always #5 clk = ~clk;

  axis_hdr_pkt_gen #(.DATA_WD(DW), .LEN_WD(LW), .CNT_WD(CW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_num_pkts(cfg_num_pkts), .cfg_max_beats(cfg_max_beats), .cfg_seed(cfg_seed),
    .cfg_pattern(cfg_pattern), .cfg_bp_en(cfg_bp_en),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out), .busy(busy), .done(done),
    .pkt_sent_cnt(pkt_sent_cnt), .pkt_rcvd_cnt(pkt_rcvd_cnt), .beat_rcvd_cnt(beat_rcvd_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] kl_tab [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
  logic [3:0] km_tab [4] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};

  logic [31:0] rec_q[$];
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          beats_total;
  int          ready_toggles;
  logic [3:0]  hc_seen = '0;
  logic [31:0] t_ins_data, t_data;
  logic [3:0]  t_ins_keep, t_keep;
  logic [1:0]  t_ins_cnt;
  logic        t_last;

  function automatic logic [31:0] m_step(input logic [31:0] v);
    logic [31:0] r;
    r = {1'b0, v[31:1]};
    if (v[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  function automatic logic [31:0] inc_word(input int b);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(b*4 + k);
    return w;
  endfunction

  task automatic run(input logic [15:0] npk, input logic [7:0] maxb, input logic [31:0] seed,
                     input logic pat, input logic bp, input logic lb, input bit stall);
    logic [31:0] m, hold_d, exp_d;
    logic [3:0]  hold_k;
    logic        prev_rdy, rdy, is_last;
    int          pkt, beat, len, hc, raw, lim, cyc, gapc, stall_left;
    bit          gap_on, stall_used;
    rec_q.delete();
    beats_total = 0; ready_toggles = 0;
    pkt = 0; beat = 0; len = 1; hc = 0; cyc = 0; gapc = 0; stall_left = 0;
    gap_on = 0; stall_used = 0;
    @(negedge clk);
    cfg_num_pkts = npk; cfg_max_beats = maxb; cfg_seed = seed;
    cfg_pattern = pat; cfg_bp_en = bp; loop_en = lb; rdy_drv = 1'b1; ready_insert = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_set", busy, 1);
    m = (seed == 32'h0) ? 32'h1 : seed;
    prev_rdy = ready_out;
    while (pkt < int'(npk) && cyc < 20000) begin
      cyc++;
      if (ready_out !== prev_rdy) ready_toggles++;
      prev_rdy = ready_out;
      check("one_channel", valid_insert & valid_in, 0);
      rdy = 1'b1;
      if (stall && !stall_used && valid_in) begin
        stall_used = 1; stall_left = 5; hold_d = data_in; hold_k = keep_in;
      end
      if (stall_left > 0) begin
        if (stall_left < 5) begin
          check("stall_data", data_in, hold_d);
          check("stall_keep", keep_in, hold_k);
        end
        stall_left--;
        rdy = 1'b0;
      end
      rdy_drv = rdy;
      if (valid_insert) begin
        if (pkt > 0) check("gap_cycles", gapc, GAP);
        gap_on = 0;
        hc  = int'(m[1:0]);
        raw = int'(m[15:8]);
        lim = (maxb == 8'd0) ? 0 : int'(maxb) - 1;
        len = ((raw > lim) ? lim : raw) + 1;
        check("hdr_cnt", byte_insert_cnt, hc);
        check("hdr_keep", keep_insert, kl_tab[hc]);
        check("hdr_data", data_insert, {8'h00, pkt[15:0], 8'hA5});
        hc_seen[hc] = 1'b1;
        if (pkt == 0) begin
          t_ins_data = data_insert; t_ins_keep = keep_insert; t_ins_cnt = byte_insert_cnt;
        end
        beat = 0;
      end else if (valid_in) begin
        if (lb ? ready_out : rdy) begin
          is_last = (beat == len - 1);
          exp_d = pat ? m : inc_word(beat);
          check("beat_data", data_in, exp_d);
          check("beat_keep", keep_in, is_last ? km_tab[hc] : 4'hF);
          check("beat_last", last_in, is_last);
          if (pkt == 0 && beat == 0) begin
            t_data = data_in; t_keep = keep_in; t_last = last_in;
          end
          rec_q.push_back(data_in);
          beats_total++;
          m = m_step(m);
          beat++;
          if (beat >= len) begin
            pkt++; gap_on = 1; gapc = 0;
          end
        end
      end else if (gap_on) begin
        gapc++;
      end
      @(negedge clk);
    end
    if (cyc >= 20000) check("timeout", 0, 1);
    check("done_pulse", done, 1);
    check("busy_clr", busy, 0);
    check("pkt_sent", pkt_sent_cnt, npk);
    @(negedge clk);
    check("done_once", done, 0);
  endtask

  initial begin
    int d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid_in", valid_in, 0);
    check("rst_valid_ins", valid_insert, 0);
    check("rst_last", last_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", data_in, 0);
    check("rst_keep", keep_in, 0);
    check("rst_bcnt", byte_insert_cnt, 0);
    check("rst_sent", pkt_sent_cnt, 0);
    check("rst_rcvd", pkt_rcvd_cnt, 0);
    check("rst_beats", beat_rcvd_cnt, 0);
    rst_n = 1'b1;

    // Single one-beat packet from seed 1
    run(16'd1, 8'd1, 32'h1, 1'b0, 1'b0, 1'b0, 0);
    check("t1_ins_cnt", t_ins_cnt, 2'd1);
    check("t1_ins_keep", t_ins_keep, 4'b0011);
    check("t1_ins_data", t_ins_data, 32'h000000A5);
    check("t1_data", t_data, 32'h03020100);
    check("t1_keep", t_keep, 4'b1100);
    check("t1_last", t_last, 1'b1);

    // Stall mid-packet, gaps between packets
    run(16'd3, 8'd4, 32'h00005EED, 1'b0, 1'b0, 1'b0, 1);

    // Repeatability of LFSR data
    run(16'd5, 8'd4, 32'h0000ACE1, 1'b1, 1'b0, 1'b0, 0);
    qa = rec_q;
    run(16'd5, 8'd4, 32'h0000ACE1, 1'b1, 1'b0, 1'b0, 0);
    qb = rec_q;
    check("rep_len", qb.size(), qa.size());
    d = 0;
    for (int i = 0; i < qa.size() && i < qb.size(); i++) if (qa[i] !== qb[i]) d++;
    check("rep_same", d, 0);
    run(16'd5, 8'd4, 32'h00001234, 1'b1, 1'b0, 1'b0, 0);
    d = 0;
    for (int i = 0; i < qa.size() && i < rec_q.size(); i++) if (qa[i] !== rec_q[i]) d++;
    check("seed_differs", d != 0, 1);

    // Loopback with random backpressure
    run(16'd100, 8'd4, 32'h0000BEEF, 1'b1, 1'b1, 1'b1, 0);
    check("lb_pkts", pkt_rcvd_cnt, 100);
    check("lb_beats", beat_rcvd_cnt, beats_total);
    check("rdy_toggles", ready_toggles > 0, 1);
    check("hc_sweep", hc_seen, 4'hF);
    loop_en = 1'b0;

    // Reset in the middle of a body
    @(negedge clk);
    cfg_num_pkts = 16'd1; cfg_max_beats = 8'd4; cfg_seed = 32'h0000ACE1;
    cfg_pattern = 1'b0; cfg_bp_en = 1'b0; rdy_drv = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !valid_in; i++) @(negedge clk);
    check("t6_body", valid_in, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_valid_in", valid_in, 0);
    check("t6_valid_ins", valid_insert, 0);
    check("t6_busy", busy, 0);
    check("t6_sent", pkt_sent_cnt, 0);
    check("t6_beats", beat_rcvd_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_num_pkts = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_done0", done, 1);
    check("t6_busy0", busy, 0);
    check("t6_noins", valid_insert, 0);
    @(negedge clk);
    check("t6_done_once", done, 0);
    check("t6_busy_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
